// File: rtl/linebuffer_scanout_pkg.sv
// Shared definitions for the line-buffer scanout block.
// Holds the FSM state type, bus widths and the sub-pixel byte selector.
package linebuffer_scanout_pkg;

    localparam int unsigned LB_ADDR_W      = 7;
    localparam int unsigned LB_WORD_W      = 128;
    localparam int unsigned PIX_W          = 8;
    localparam int unsigned SUBPIX_PER_PIX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Pixel k of a word is byte (4k + sel).
    function automatic logic [PIX_W-1:0] pick_subpix(input logic [LB_WORD_W-1:0] word,
                                                     input logic [1:0]           k,
                                                     input int unsigned          sel);
        logic [PIX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LB_WORD_W / PIX_W; i++) begin
            if (i == SUBPIX_PER_PIX * 32'(k) + sel) r = word[PIX_W*i +: PIX_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/scanout_word_fifo.sv
// Two-entry word FIFO between line-buffer read data and the pixel serialiser.
// Ports:
//   clk_draw, rst_draw_n : clock, asynchronous active-low reset
//   push, push_data      : write one 128-bit word
//   pop                  : retire the head word
//   head                 : current head word
//   count                : words held (0..2)
module scanout_word_fifo
    import linebuffer_scanout_pkg::*;
(
    input  logic                 clk_draw,
    input  logic                 rst_draw_n,
    input  logic                 push,
    input  logic [LB_WORD_W-1:0] push_data,
    input  logic                 pop,
    output logic [LB_WORD_W-1:0] head,
    output logic [1:0]           count
);

    logic [LB_WORD_W-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/linebuffer_scanout.sv
// Scans one line out of the line buffer as a pixel stream.
// Reads words 0..LINE_WORDS-1 (one-cycle read latency), clears each word the
// cycle after it is captured, and emits four pixels per word with a
// valid/ready handshake. pix_last flags the final pixel; busy covers the line.
// Ports:
//   clk_draw, rst_draw_n              : clock, asynchronous active-low reset
//   line_start                        : start strobe (ignored unless idle)
//   lb_rd_en, lb_rd_addr, lb_rd_data  : line-buffer read port
//   lb_clr_en, lb_clr_addr            : clear-after-read port
//   pix_data, pix_valid, pix_ready    : pixel stream
//   pix_last, busy                    : end-of-line marker, line in progress
module linebuffer_scanout
    import linebuffer_scanout_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 80,
    parameter int unsigned SUBPIX_SEL = 0
) (
    input  logic                 clk_draw,
    input  logic                 rst_draw_n,
    input  logic                 line_start,
    output logic                 lb_rd_en,
    output logic [LB_ADDR_W-1:0] lb_rd_addr,
    input  logic [LB_WORD_W-1:0] lb_rd_data,
    output logic                 lb_clr_en,
    output logic [LB_ADDR_W-1:0] lb_clr_addr,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_last,
    output logic                 busy
);

    localparam int unsigned NUM_PIX = LINE_WORDS * SUBPIX_PER_PIX;
    localparam int unsigned WCNT_W  = $clog2(LINE_WORDS + 1);
    localparam int unsigned PCNT_W  = $clog2(NUM_PIX);

    scan_state_e          state_q, state_d;
    logic [WCNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                 rd_en_q, rd_en_d;
    logic [LB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [PCNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic                 cap_q;
    logic [LB_ADDR_W-1:0] cap_addr_q;
    logic                 clr_en_q;
    logic [LB_ADDR_W-1:0] clr_addr_q;

    logic [LB_WORD_W-1:0] fifo_head;
    logic [1:0]           fifo_count;
    logic                 fifo_pop;
    logic                 handshake;
    logic                 last_pix;
    logic                 can_issue;
    logic                 issue;

    // Buffered words plus both read-pipeline stages must leave room for one more.
    assign can_issue = (3'(fifo_count) + 3'(rd_en_q) + 3'(cap_q)) < 3'd2;
    assign pix_valid = (fifo_count != 2'd0);
    assign handshake = pix_valid && pix_ready;
    assign last_pix  = (pix_cnt_q == PCNT_W'(NUM_PIX - 1));
    assign fifo_pop  = handshake && (pix_cnt_q[1:0] == 2'd3);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        pix_cnt_d = pix_cnt_q;
        issue     = 1'b0;

        unique case (state_q)
            IDLE:    issue = line_start;
            RUN:     issue = can_issue;
            DRAIN:   issue = 1'b0;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = LB_ADDR_W'(rd_cnt_q);
            rd_cnt_d  = rd_cnt_q + WCNT_W'(1);
            state_d   = (rd_cnt_q == WCNT_W'(LINE_WORDS - 1)) ? DRAIN : RUN;
        end

        if (handshake) begin
            pix_cnt_d = pix_cnt_q + PCNT_W'(1);
            if (last_pix) begin
                pix_cnt_d = '0;
                rd_cnt_d  = '0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pix_cnt_q  <= '0;
            cap_q      <= 1'b0;
            cap_addr_q <= '0;
            clr_en_q   <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            pix_cnt_q <= pix_cnt_d;
            // cap_q marks the cycle lb_rd_data is valid; the word is pushed then.
            cap_q     <= rd_en_q;
            if (rd_en_q) cap_addr_q <= rd_addr_q;
            clr_en_q  <= cap_q;
            if (cap_q) clr_addr_q <= cap_addr_q;
        end
    end

    scanout_word_fifo u_word_fifo (
        .clk_draw   (clk_draw),
        .rst_draw_n (rst_draw_n),
        .push       (cap_q),
        .push_data  (lb_rd_data),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign lb_rd_en    = rd_en_q;
    assign lb_rd_addr  = rd_addr_q;
    assign lb_clr_en   = clr_en_q;
    assign lb_clr_addr = clr_addr_q;
    assign pix_data    = pix_valid ? pick_subpix(fifo_head, pix_cnt_q[1:0], SUBPIX_SEL) : '0;
    assign pix_last    = pix_valid && last_pix;
    assign busy        = (state_q != IDLE);

endmodule
